// File: rtl/scroll_monitor_pkg.sv
// Shared definitions for the scroll bus monitor: tracking states, position
// range and the pattern a freshly reset generator drives.
package scroll_monitor_pkg;

  localparam int POS_W = 3;

  localparam logic [POS_W-1:0] P_MIN = 3'd0;
  localparam logic [POS_W-1:0] P_MAX = 3'd6;

  localparam logic [7:0] RESET_PATTERN = 8'b1100_0000;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_RIGHT    = 2'd1,
    ST_LEFT     = 2'd2
  } state_t;

endpackage

// File: rtl/scroll_decode.sv
// Combinational decode of an LED pattern into the lower lit bit of a
// two-wide block; anything other than exactly two adjacent set bits is illegal.
module scroll_decode
  import scroll_monitor_pkg::*;
(
  input  logic [7:0]       pattern_in,
  output logic [POS_W-1:0] p,
  output logic             legal
);

  logic [7:0] block;

  always_comb begin
    p     = P_MIN;
    legal = 1'b0;
    block = 8'b0000_0011;
    for (int i = 0; i <= int'(P_MAX); i++) begin
      if (pattern_in == block) begin
        p     = POS_W'(i);
        legal = 1'b1;
      end
      block = block << 1;
    end
  end

endmodule

// File: rtl/scroll_monitor.sv
// Reader end of the bouncing two-LED scroll bus: tracks the block, flags bad
// shapes and illegal steps, and counts bottom turnarounds.
//
//   state       | meaning
//   ST_UNLOCKED | hunting for two adjacent positions to pick a direction
//   ST_RIGHT    | locked, block moving toward the LSB (p decreasing)
//   ST_LEFT     | locked, block moving toward the MSB (p increasing)
module scroll_monitor
  import scroll_monitor_pkg::*;
#(
  parameter int TOP_DWELL = 1,
  parameter int BOT_DWELL = 0,
  parameter int SWEEP_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_en,
  input  logic [7:0]         pattern_in,
  output logic [POS_W-1:0]   pos,
  output logic               dir,
  output logic               locked,
  output logic               err_shape,
  output logic               err_step,
  output logic               err_sticky,
  output logic [SWEEP_W-1:0] sweep_cnt
);

  localparam logic [1:0]         TOP_D     = 2'(TOP_DWELL);
  localparam logic [1:0]         BOT_D     = 2'(BOT_DWELL);
  localparam logic [SWEEP_W-1:0] SWEEP_MAX = '1;

  logic [POS_W-1:0] dec_p;
  logic             dec_legal;

  scroll_decode u_decode (
    .pattern_in (pattern_in),
    .p          (dec_p),
    .legal      (dec_legal)
  );

  state_t           state;
  logic [POS_W-1:0] anchor;
  logic             anchor_vld;
  logic [1:0]       dwell_cnt;

  logic step_ok;
  logic dwell_hit;
  logic turn;

  // Classify a legal sample against the current locked position.
  always_comb begin
    step_ok   = 1'b1;
    dwell_hit = 1'b0;
    turn      = 1'b0;
    case (state)
      ST_RIGHT: begin
        if (pos != P_MIN) begin
          step_ok = (dec_p == pos - 3'd1);
        end else if (dec_p == P_MIN && dwell_cnt != BOT_D) begin
          dwell_hit = 1'b1;
        end else if (dec_p == P_MIN + 3'd1 && dwell_cnt == BOT_D) begin
          turn = 1'b1;
        end else begin
          step_ok = 1'b0;
        end
      end
      ST_LEFT: begin
        if (pos != P_MAX) begin
          step_ok = (dec_p == pos + 3'd1);
        end else if (dec_p == P_MAX && dwell_cnt != TOP_D) begin
          dwell_hit = 1'b1;
        end else if (dec_p == P_MAX - 3'd1 && dwell_cnt == TOP_D) begin
          turn = 1'b1;
        end else begin
          step_ok = 1'b0;
        end
      end
      default: step_ok = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_UNLOCKED;
      anchor     <= P_MIN;
      anchor_vld <= 1'b0;
      dwell_cnt  <= 2'd0;
      pos        <= P_MIN;
      dir        <= 1'b0;
      locked     <= 1'b0;
      err_shape  <= 1'b0;
      err_step   <= 1'b0;
      err_sticky <= 1'b0;
      sweep_cnt  <= '0;
    end else begin
      err_shape <= 1'b0;
      err_step  <= 1'b0;
      if (sample_en) begin
        if (!dec_legal) begin
          // Position is held so the last good location stays visible.
          err_shape  <= 1'b1;
          err_sticky <= 1'b1;
          state      <= ST_UNLOCKED;
          locked     <= 1'b0;
          anchor_vld <= 1'b0;
          dwell_cnt  <= 2'd0;
        end else if (state == ST_UNLOCKED) begin
          pos        <= dec_p;
          dwell_cnt  <= 2'd0;
          anchor     <= dec_p;
          anchor_vld <= 1'b1;
          if (anchor_vld && anchor != P_MIN && dec_p == anchor - 3'd1) begin
            state  <= ST_RIGHT;
            dir    <= 1'b0;
            locked <= 1'b1;
          end else if (anchor_vld && anchor != P_MAX && dec_p == anchor + 3'd1) begin
            state  <= ST_LEFT;
            dir    <= 1'b1;
            locked <= 1'b1;
          end
        end else if (!step_ok) begin
          err_step   <= 1'b1;
          err_sticky <= 1'b1;
          state      <= ST_UNLOCKED;
          locked     <= 1'b0;
          anchor     <= dec_p;
          anchor_vld <= 1'b1;
          pos        <= dec_p;
          dwell_cnt  <= 2'd0;
        end else if (dwell_hit) begin
          dwell_cnt <= dwell_cnt + 2'd1;
        end else begin
          pos       <= dec_p;
          dwell_cnt <= 2'd0;
          if (turn) begin
            state <= (state == ST_RIGHT) ? ST_LEFT : ST_RIGHT;
            dir   <= (state == ST_RIGHT);
            if (state == ST_RIGHT && sweep_cnt != SWEEP_MAX) begin
              sweep_cnt <= sweep_cnt + 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_scroll_monitor.sv
// Bench for scroll_monitor: the legal bounce is modelled as one periodic
// position table with a phase pointer, independent of the RTL state machine.
module tb_scroll_monitor;
  import scroll_monitor_pkg::*;

  localparam int TOP_DW = 1;
  localparam int BOT_DW = 0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_en = 1'b0;
  logic [7:0] pattern_in = 8'h00;

  logic [2:0] pos, pos2;
  logic       dir, locked, err_shape, err_step, err_sticky;
  logic       dir2, locked2, err_shape2, err_step2, err_sticky2;
  logic [7:0] sweep_cnt;
  logic [1:0] sweep_cnt2;

  scroll_monitor #(.TOP_DWELL(TOP_DW), .BOT_DWELL(BOT_DW), .SWEEP_W(8)) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .pattern_in(pattern_in),
    .pos(pos), .dir(dir), .locked(locked), .err_shape(err_shape),
    .err_step(err_step), .err_sticky(err_sticky), .sweep_cnt(sweep_cnt)
  );

  scroll_monitor #(.TOP_DWELL(TOP_DW), .BOT_DWELL(BOT_DW), .SWEEP_W(2)) dut2 (
    .clk(clk), .reset(reset), .sample_en(sample_en), .pattern_in(pattern_in),
    .pos(pos2), .dir(dir2), .locked(locked2), .err_shape(err_shape2),
    .err_step(err_step2), .err_sticky(err_sticky2), .sweep_cnt(sweep_cnt2)
  );

  always #5 clk = ~clk;

  wire [7:0] dut_flags = {locked, pos, dir, err_shape, err_step, err_sticky};

  int checks = 0;
  int failures = 0;

  // One full bounce period: top dwell, descent, bottom dwell, ascent.
  int seq [32];
  bit sdir [32];
  int n_seq;
  int sweep_idx;

  bit m_locked, m_dir, m_sticky, m_anchor_vld, e_shape, e_step;
  int m_pos, m_anchor, m_phase, m_sweep;

  task automatic build_table();
    n_seq = 0;
    for (int k = 0; k <= TOP_DW; k++) begin seq[n_seq] = 6; sdir[n_seq] = 1; n_seq++; end
    for (int v = 5; v >= 1; v--)      begin seq[n_seq] = v; sdir[n_seq] = 0; n_seq++; end
    for (int k = 0; k <= BOT_DW; k++) begin seq[n_seq] = 0; sdir[n_seq] = 0; n_seq++; end
    for (int v = 1; v <= 5; v++) begin
      if (v == 1) sweep_idx = n_seq;
      seq[n_seq] = v; sdir[n_seq] = 1; n_seq++;
    end
  endtask

  function automatic logic [7:0] pat_of(int p);
    logic [7:0] b;
    b = 8'h03;
    return b << p;
  endfunction

  function automatic int find_phase(int p, bit d);
    for (int i = 0; i < n_seq; i++) if (seq[i] == p && sdir[i] == d) return i;
    return 0;
  endfunction

  function automatic logic [7:0] exp_flags();
    return {m_locked, 3'(m_pos), m_dir, e_shape, e_step, m_sticky};
  endfunction

  function automatic logic [7:0] exp_sweep8();
    return (m_sweep > 255) ? 8'hFF : 8'(m_sweep);
  endfunction

  function automatic logic [1:0] exp_sweep2();
    return (m_sweep > 3) ? 2'd3 : 2'(m_sweep);
  endfunction

  task automatic model_reset();
    m_locked = 0; m_dir = 0; m_sticky = 0; m_anchor_vld = 0;
    e_shape = 0; e_step = 0;
    m_pos = 0; m_anchor = 0; m_phase = 0; m_sweep = 0;
  endtask

  task automatic model_step(input logic [7:0] pat);
    int p;
    bit legal;
    int nxt;
    legal = 0; p = 0;
    for (int i = 0; i <= 6; i++) if (pat == pat_of(i)) begin legal = 1; p = i; end
    e_shape = 0; e_step = 0;
    if (!legal) begin
      e_shape = 1; m_sticky = 1; m_locked = 0; m_anchor_vld = 0;
    end else if (!m_locked) begin
      m_pos = p;
      if (m_anchor_vld && p == m_anchor - 1) begin
        m_locked = 1; m_dir = 0; m_phase = find_phase(p, 0);
      end else if (m_anchor_vld && p == m_anchor + 1) begin
        m_locked = 1; m_dir = 1; m_phase = find_phase(p, 1);
      end
      m_anchor = p; m_anchor_vld = 1;
    end else begin
      nxt = (m_phase + 1) % n_seq;
      if (p == seq[nxt]) begin
        m_phase = nxt; m_pos = p; m_dir = sdir[nxt];
        if (nxt == sweep_idx) m_sweep++;
      end else begin
        e_step = 1; m_sticky = 1; m_locked = 0;
        m_anchor = p; m_anchor_vld = 1; m_pos = p;
      end
    end
  endtask

  task automatic apply(input logic [7:0] pat, input logic en);
    pattern_in = pat;
    sample_en  = en;
    @(posedge clk);
    #1;
    if (en) model_step(pat);
    else begin e_shape = 0; e_step = 0; end
    sample_en = 1'b0;
  endtask

  task automatic do_reset(input logic en, input logic [7:0] pat);
    reset = 1'b1; sample_en = en; pattern_in = pat;
    @(posedge clk);
    #1;
    reset = 1'b0; sample_en = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset(1'b0, 8'h00);
    checks++;
    if (dut_flags !== 8'h00) begin failures++; $display("FAIL reset_flags got=%b exp=%b", dut_flags, 8'h00); end
    checks++;
    if (sweep_cnt !== 8'd0) begin failures++; $display("FAIL reset_sweep got=%0d exp=0", sweep_cnt); end
    checks++;
    if (sweep_cnt2 !== 2'd0) begin failures++; $display("FAIL reset_sweep2 got=%0d exp=0", sweep_cnt2); end
  endtask

  task automatic test_periods();
    do_reset(1'b0, 8'h00);
    for (int k = 0; k < 2 * n_seq; k++) begin
      apply(pat_of(seq[k % n_seq]), 1'b1);
      checks++;
      if (dut_flags !== exp_flags()) begin
        failures++; $display("FAIL periods[%0d] flags got=%b exp=%b", k, dut_flags, exp_flags());
      end
      checks++;
      if (sweep_cnt !== exp_sweep8()) begin
        failures++; $display("FAIL periods[%0d] sweep got=%0d exp=%0d", k, sweep_cnt, exp_sweep8());
      end
    end
    checks++;
    if (sweep_cnt !== 8'd2 || err_sticky !== 1'b0) begin
      failures++; $display("FAIL periods_end sweep=%0d sticky=%b exp sweep=2 sticky=0", sweep_cnt, err_sticky);
    end
  endtask

  task automatic test_shape();
    apply(8'hA0, 1'b1);
    checks++;
    if (dut_flags !== exp_flags() || err_shape !== 1'b1 || locked !== 1'b0 || err_sticky !== 1'b1) begin
      failures++; $display("FAIL shape_err flags got=%b exp=%b", dut_flags, exp_flags());
    end
    apply(8'h00, 1'b0);
    checks++;
    if (dut_flags !== exp_flags() || err_shape !== 1'b0) begin
      failures++; $display("FAIL shape_pulse flags got=%b exp=%b", dut_flags, exp_flags());
    end
    apply(8'h60, 1'b1);
    apply(8'h30, 1'b1);
    checks++;
    if (dut_flags !== exp_flags() || {locked, dir, pos} !== {1'b1, 1'b0, 3'd4}) begin
      failures++; $display("FAIL shape_relock flags got=%b exp=%b", dut_flags, exp_flags());
    end
  endtask

  task automatic test_step();
    apply(8'h60, 1'b1);
    checks++;
    if (dut_flags !== exp_flags() || err_step !== 1'b1) begin
      failures++; $display("FAIL step_err flags got=%b exp=%b", dut_flags, exp_flags());
    end
    apply(8'h18, 1'b1);
    checks++;
    if (dut_flags !== exp_flags() || locked !== 1'b0 || pos !== 3'd3) begin
      failures++; $display("FAIL step_anchor flags got=%b exp=%b", dut_flags, exp_flags());
    end
    apply(8'h0C, 1'b1);
    checks++;
    if (dut_flags !== exp_flags() || locked !== 1'b1 || dir !== 1'b0) begin
      failures++; $display("FAIL step_relock flags got=%b exp=%b", dut_flags, exp_flags());
    end
  endtask

  task automatic test_no_dwell();
    logic [7:0] pats [4] = '{8'h30, 8'h60, 8'hC0, 8'h60};
    logic [7:0] sweep_before;
    sweep_before = exp_sweep8();
    foreach (pats[i]) begin
      apply(pats[i], 1'b1);
      checks++;
      if (dut_flags !== exp_flags()) begin
        failures++; $display("FAIL no_dwell[%0d] flags got=%b exp=%b", i, dut_flags, exp_flags());
      end
    end
    checks++;
    if (err_step !== 1'b1 || err_sticky !== 1'b1 || sweep_cnt !== sweep_before) begin
      failures++; $display("FAIL no_dwell_end step=%b sticky=%b sweep=%0d exp 1 1 %0d",
                           err_step, err_sticky, sweep_cnt, sweep_before);
    end
  endtask

  task automatic test_hold();
    for (int k = 0; k < 100; k++) begin
      apply(8'($urandom), 1'b0);
      checks++;
      if (dut_flags !== exp_flags() || sweep_cnt !== exp_sweep8()) begin
        failures++; $display("FAIL hold[%0d] flags got=%b exp=%b sweep=%0d", k, dut_flags, exp_flags(), sweep_cnt);
      end
    end
    do_reset(1'b1, 8'h05);
    checks++;
    if (dut_flags !== 8'h00 || sweep_cnt !== 8'd0 || sweep_cnt2 !== 2'd0) begin
      failures++; $display("FAIL reset_over_sample flags got=%b sweep=%0d exp 0", dut_flags, sweep_cnt);
    end
  endtask

  task automatic test_gen_reset();
    logic [7:0] pats [8] = '{8'hC0, 8'hC0, 8'h60, 8'h30, 8'h18, RESET_PATTERN, 8'hC0, 8'h60};
    do_reset(1'b0, 8'h00);
    foreach (pats[i]) begin
      apply(pats[i], 1'b1);
      checks++;
      if (dut_flags !== exp_flags()) begin
        failures++; $display("FAIL gen_reset[%0d] flags got=%b exp=%b", i, dut_flags, exp_flags());
      end
      if (i == 5) begin
        checks++;
        if (err_step !== 1'b1) begin failures++; $display("FAIL gen_reset_step got=%b exp=1", err_step); end
      end
    end
    checks++;
    if (locked !== 1'b1 || dir !== 1'b0) begin
      failures++; $display("FAIL gen_reset_relock locked=%b dir=%b exp 1 0", locked, dir);
    end
  endtask

  task automatic test_random();
    int ph;
    logic [7:0] pat;
    do_reset(1'b0, 8'h00);
    ph = 0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 24) == 0) pat = 8'($urandom);
      else begin
        if ($urandom_range(0, 19) == 0) ph = $urandom_range(0, n_seq - 1);
        pat = pat_of(seq[ph]);
      end
      if ($urandom_range(0, 4) != 0) begin
        apply(pat, 1'b1);
        ph = (ph + 1) % n_seq;
      end else begin
        apply(pat, 1'b0);
      end
      checks++;
      if (dut_flags !== exp_flags() || sweep_cnt !== exp_sweep8() || sweep_cnt2 !== exp_sweep2()) begin
        failures++; $display("FAIL random[%0d] pat=%h flags got=%b exp=%b sweep=%0d/%0d exp=%0d/%0d",
                             k, pat, dut_flags, exp_flags(), sweep_cnt, sweep_cnt2, exp_sweep8(), exp_sweep2());
      end
    end
  endtask

  task automatic test_saturate();
    int exp_sat [5] = '{1, 2, 3, 3, 3};
    int turns;
    do_reset(1'b0, 8'h00);
    turns = 0;
    for (int per = 0; per < 5; per++) begin
      for (int ph = 0; ph < n_seq; ph++) begin
        apply(pat_of(seq[ph]), 1'b1);
        if (ph == sweep_idx) begin
          checks++;
          if (sweep_cnt2 !== 2'(exp_sat[turns]) || sweep_cnt2 !== exp_sweep2()) begin
            failures++; $display("FAIL saturate[%0d] got=%0d exp=%0d", turns, sweep_cnt2, exp_sat[turns]);
          end
          turns++;
        end
      end
    end
    checks++;
    if (sweep_cnt !== 8'd5) begin failures++; $display("FAIL saturate_wide got=%0d exp=5", sweep_cnt); end
  endtask

  initial begin
    build_table();
    model_reset();
    test_reset();
    test_periods();
    test_shape();
    test_step();
    test_no_dwell();
    test_hold();
    test_gen_reset();
    test_random();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
